// File: rtl/rob_commit_if.sv
// Issue, CDB and commit/flush signals between the core pipeline and the
// reorder buffer.
interface rob_commit_if #(
  parameter int unsigned ROB_W  = 4,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned DATA_W = 32
) ();
    logic              ready;
    logic              issue_valid;
    logic              issue_has_rd;
    logic [REG_W-1:0]  issue_rd;
    logic              issue_is_branch;
    logic              issue_pred_taken;
    logic [DATA_W-1:0] issue_alt_pc;
    logic [ROB_W-1:0]  alloc_robpos;
    logic              full;
    logic              cdb_valid;
    logic [ROB_W-1:0]  cdb_robpos;
    logic [DATA_W-1:0] cdb_val;
    logic              cdb_taken;
    logic              unlock;
    logic [REG_W-1:0]  unlock_rd;
    logic [ROB_W-1:0]  unlock_robpos;
    logic [DATA_W-1:0] unlock_val;
    logic              clear;
    logic [DATA_W-1:0] clear_pc;

    modport master (
        output ready, issue_valid, issue_has_rd, issue_rd, issue_is_branch,
               issue_pred_taken, issue_alt_pc, cdb_valid, cdb_robpos, cdb_val,
               cdb_taken,
        input  alloc_robpos, full, unlock, unlock_rd, unlock_robpos,
               unlock_val, clear, clear_pc
    );

    modport slave (
        input  ready, issue_valid, issue_has_rd, issue_rd, issue_is_branch,
               issue_pred_taken, issue_alt_pc, cdb_valid, cdb_robpos, cdb_val,
               cdb_taken,
        output alloc_robpos, full, unlock, unlock_rd, unlock_robpos,
               unlock_val, clear, clear_pc
    );
endinterface

// File: rtl/rob_commit.sv
// Reorder buffer: in-order allocation, CDB result capture, in-order commit
// driving register-file unlock, and full flush on branch mispredict.
module rob_commit #(
    parameter int unsigned ROB_SIZE = 16,
    parameter int unsigned ROB_W    = 4,
    parameter int unsigned REG_W    = 5,
    parameter int unsigned DATA_W   = 32
) (
    input logic          clk_i,
    input logic          reset_i,
    rob_commit_if.slave  bus
);
    localparam logic [ROB_W:0] FULL_CNT = (ROB_W+1)'(ROB_SIZE);

    logic [ROB_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [ROB_W:0]      count_q, count_d;
    logic [ROB_SIZE-1:0] busy_q, busy_d, done_q, done_d;

    logic                has_rd_q [ROB_SIZE];
    logic [REG_W-1:0]    rd_q     [ROB_SIZE];
    logic                is_br_q  [ROB_SIZE];
    logic                pred_q   [ROB_SIZE];
    logic                taken_q  [ROB_SIZE];
    logic [DATA_W-1:0]   val_q    [ROB_SIZE];
    logic [DATA_W-1:0]   alt_pc_q [ROB_SIZE];

    logic                unlock_q, unlock_d, clear_q, clear_d;
    logic [REG_W-1:0]    unlock_rd_q, unlock_rd_d;
    logic [ROB_W-1:0]    unlock_pos_q, unlock_pos_d;
    logic [DATA_W-1:0]   unlock_val_q, unlock_val_d, clear_pc_q, clear_pc_d;

    logic full, do_alloc, do_cdb, do_commit, do_flush;

    always_comb begin
        full      = (count_q == FULL_CNT);
        do_alloc  = bus.ready && bus.issue_valid && !full && !clear_q;
        do_cdb    = bus.ready && bus.cdb_valid && !clear_q && busy_q[bus.cdb_robpos];
        do_commit = bus.ready && !clear_q && busy_q[head_q] && done_q[head_q];
        do_flush  = do_commit && is_br_q[head_q] && (taken_q[head_q] != pred_q[head_q]);
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        busy_d  = busy_q;
        done_d  = done_q;
        count_d = count_q + (ROB_W+1)'(do_alloc) - (ROB_W+1)'(do_commit);
        if (do_cdb) done_d[bus.cdb_robpos] = 1'b1;
        if (do_alloc) begin
            busy_d[tail_q] = 1'b1;
            done_d[tail_q] = 1'b0;
            tail_d         = tail_q + 1'b1;
        end
        if (do_commit) begin
            busy_d[head_q] = 1'b0;
            head_d         = head_q + 1'b1;
        end
        // A mispredict empties the buffer and wins over a same-edge allocation.
        if (do_flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            busy_d  = '0;
            done_d  = '0;
        end

        unlock_d     = do_commit && has_rd_q[head_q];
        unlock_rd_d  = do_commit ? rd_q[head_q]  : unlock_rd_q;
        unlock_pos_d = do_commit ? head_q        : unlock_pos_q;
        unlock_val_d = do_commit ? val_q[head_q] : unlock_val_q;
        clear_d      = do_flush;
        clear_pc_d   = do_flush ? alt_pc_q[head_q] : clear_pc_q;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            busy_q       <= '0;
            done_q       <= '0;
            unlock_q     <= 1'b0;
            unlock_rd_q  <= '0;
            unlock_pos_q <= '0;
            unlock_val_q <= '0;
            clear_q      <= 1'b0;
            clear_pc_q   <= '0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            unlock_q     <= unlock_d;
            unlock_rd_q  <= unlock_rd_d;
            unlock_pos_q <= unlock_pos_d;
            unlock_val_q <= unlock_val_d;
            clear_q      <= clear_d;
            clear_pc_q   <= clear_pc_d;
        end
    end

    // Payload is only meaningful while busy, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (do_alloc) begin
            has_rd_q[tail_q] <= bus.issue_has_rd;
            rd_q[tail_q]     <= bus.issue_rd;
            is_br_q[tail_q]  <= bus.issue_is_branch;
            pred_q[tail_q]   <= bus.issue_pred_taken;
            alt_pc_q[tail_q] <= bus.issue_alt_pc;
        end
        if (do_cdb) begin
            val_q[bus.cdb_robpos]   <= bus.cdb_val;
            taken_q[bus.cdb_robpos] <= bus.cdb_taken;
        end
    end

    assign bus.alloc_robpos  = tail_q;
    assign bus.full          = full;
    assign bus.unlock        = unlock_q;
    assign bus.unlock_rd     = unlock_rd_q;
    assign bus.unlock_robpos = unlock_pos_q;
    assign bus.unlock_val    = unlock_val_q;
    assign bus.clear         = clear_q;
    assign bus.clear_pc      = clear_pc_q;
endmodule

// File: tb/tb_rob_commit.sv
// Randomized and directed checks of rob_commit against a queue-based
// program-order model of the reorder buffer.
module tb_rob_commit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    rob_commit_if #(.ROB_W(4), .REG_W(5), .DATA_W(32)) bus ();
    rob_commit #(.ROB_SIZE(16), .ROB_W(4), .REG_W(5), .DATA_W(32)) dut (
        .clk_i(clk), .reset_i(reset), .bus(bus)
    );

    typedef struct {
        bit        has_rd;
        bit [4:0]  rd;
        bit        br;
        bit        pred;
        bit        taken;
        bit [31:0] val;
        bit [31:0] alt;
        bit        done;
        bit [3:0]  pos;
    } ent_t;

    ent_t      rob[$];
    int        mtail;
    bit        m_unlock, m_clear;
    bit [4:0]  m_rd;
    bit [3:0]  m_pos;
    bit [31:0] m_val, m_cpc;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        rob.delete();
        mtail = 0; m_unlock = 0; m_clear = 0;
        m_rd = 0; m_pos = 0; m_val = 0; m_cpc = 0;
    endfunction

    // Evaluated with the inputs present at the clock edge just taken.
    function automatic void model_step();
        bit   com = 0;
        bit   fl  = 0;
        int   sz;
        ent_t h, e;
        sz = rob.size();
        m_unlock = 0;
        if (bus.ready && !m_clear) begin
            if (sz > 0 && rob[0].done) begin
                h = rob[0]; com = 1;
                m_unlock = h.has_rd; m_rd = h.rd; m_pos = h.pos; m_val = h.val;
                fl = h.br && (h.taken != h.pred);
                if (fl) m_cpc = h.alt;
            end
            if (bus.cdb_valid)
                foreach (rob[i])
                    if (rob[i].pos == bus.cdb_robpos) begin
                        rob[i].done = 1; rob[i].val = bus.cdb_val; rob[i].taken = bus.cdb_taken;
                    end
            if (com) void'(rob.pop_front());
            if (fl) begin
                rob.delete(); mtail = 0;
            end else if (bus.issue_valid && sz < 16) begin
                e.has_rd = bus.issue_has_rd; e.rd = bus.issue_rd; e.br = bus.issue_is_branch;
                e.pred = bus.issue_pred_taken; e.alt = bus.issue_alt_pc; e.taken = 0;
                e.val = 0; e.done = 0; e.pos = 4'(mtail);
                rob.push_back(e);
                mtail = (mtail + 1) % 16;
            end
        end
        m_clear = fl;
    endfunction

    task automatic compare_all();
        check_eq("alloc_robpos",  32'(bus.alloc_robpos),  32'(mtail));
        check_eq("full",          32'(bus.full),          32'(rob.size() == 16));
        check_eq("unlock",        32'(bus.unlock),        32'(m_unlock));
        check_eq("unlock_rd",     32'(bus.unlock_rd),     32'(m_rd));
        check_eq("unlock_robpos", 32'(bus.unlock_robpos), 32'(m_pos));
        check_eq("unlock_val",    bus.unlock_val,         m_val);
        check_eq("clear",         32'(bus.clear),         32'(m_clear));
        check_eq("clear_pc",      bus.clear_pc,           m_cpc);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        bus.ready = 1; bus.issue_valid = 0; bus.issue_has_rd = 0; bus.issue_rd = 0;
        bus.issue_is_branch = 0; bus.issue_pred_taken = 0; bus.issue_alt_pc = 0;
        bus.cdb_valid = 0; bus.cdb_robpos = 0; bus.cdb_val = 0; bus.cdb_taken = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 0;
        #3;
        model_reset();
        @(negedge clk);
        reset = 1;
    endtask

    task automatic issue(input bit has_rd, input bit [4:0] rd, input bit br,
                         input bit pred, input bit [31:0] alt);
        idle_inputs();
        bus.issue_valid = 1; bus.issue_has_rd = has_rd; bus.issue_rd = rd;
        bus.issue_is_branch = br; bus.issue_pred_taken = pred; bus.issue_alt_pc = alt;
        cycle();
    endtask

    task automatic cdb(input bit [3:0] pos, input bit [31:0] val, input bit taken);
        idle_inputs();
        bus.cdb_valid = 1; bus.cdb_robpos = pos; bus.cdb_val = val; bus.cdb_taken = taken;
        cycle();
    endtask

    task automatic idle();
        idle_inputs();
        cycle();
    endtask

    initial begin
        idle_inputs();
        model_reset();
        #2;
        check_eq("reset_unlock", 32'(bus.unlock), 0);
        check_eq("reset_alloc",  32'(bus.alloc_robpos), 0);
        do_reset();

        // In-order commit with out-of-order completion
        for (int i = 1; i <= 3; i++) begin
            issue(1, 5'(i), 0, 0, 0);
            check_eq("t1_alloc", 32'(bus.alloc_robpos), 32'(i));
        end
        cdb(1, 32'hA, 0);
        cdb(0, 32'hB, 0);
        idle();
        check_eq("t1_unl0", 32'(bus.unlock), 1);
        check_eq("t1_pos0", 32'(bus.unlock_robpos), 0);
        check_eq("t1_val0", bus.unlock_val, 32'hB);
        idle();
        check_eq("t1_pos1", 32'(bus.unlock_robpos), 1);
        check_eq("t1_val1", bus.unlock_val, 32'hA);
        idle();
        check_eq("t1_hold2", 32'(bus.unlock), 0);

        // Fill, refuse while full, wrap
        do_reset();
        for (int i = 0; i < 16; i++) issue(1, 5'(i), 0, 0, 0);
        check_eq("t2_full", 32'(bus.full), 1);
        check_eq("t2_wrap", 32'(bus.alloc_robpos), 0);
        issue(1, 9, 0, 0, 0);
        check_eq("t2_17th", 32'(bus.alloc_robpos), 0);
        cdb(0, 32'h55, 0);
        issue(1, 9, 0, 0, 0);
        check_eq("t2_refused", 32'(bus.full), 0);
        issue(1, 9, 0, 0, 0);
        check_eq("t2_refull", 32'(bus.full), 1);
        check_eq("t2_pos", 32'(bus.alloc_robpos), 1);

        // Branch mispredict flush with younger done entries
        do_reset();
        issue(0, 0, 1, 0, 32'h1000);
        issue(1, 7, 0, 0, 0);
        issue(1, 8, 0, 0, 0);
        cdb(1, 32'h11, 0);
        cdb(2, 32'h22, 0);
        cdb(0, 32'h0, 1);
        bus.issue_valid = 1;
        cycle();
        check_eq("t3_clear", 32'(bus.clear), 1);
        check_eq("t3_cpc", bus.clear_pc, 32'h1000);
        check_eq("t3_nounl", 32'(bus.unlock), 0);
        cycle();
        check_eq("t3_clr_off", 32'(bus.clear), 0);
        check_eq("t3_empty", 32'(bus.alloc_robpos), 0);
        repeat (3) idle();

        // Mispredicted jalr with rd: unlock and clear together
        issue(1, 5, 1, 0, 32'h2000);
        cdb(0, 32'h44, 1);
        idle();
        check_eq("t4_unl", 32'(bus.unlock), 1);
        check_eq("t4_rd", 32'(bus.unlock_rd), 5);
        check_eq("t4_val", bus.unlock_val, 32'h44);
        check_eq("t4_clr", 32'(bus.clear), 1);
        idle();

        // Global stall
        do_reset();
        issue(1, 3, 0, 0, 0);
        issue(1, 4, 0, 0, 0);
        cdb(0, 32'h77, 0);
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            bus.ready = 0; bus.issue_valid = 1; bus.cdb_valid = 1; bus.cdb_robpos = 1;
            cycle();
            check_eq("t5_stall_unl", 32'(bus.unlock), 0);
            check_eq("t5_stall_pos", 32'(bus.alloc_robpos), 2);
        end
        idle();
        check_eq("t5_resume", 32'(bus.unlock), 1);
        check_eq("t5_rval", bus.unlock_val, 32'h77);
        idle();
        check_eq("t5_nocdb1", 32'(bus.unlock), 0);

        // Asynchronous reset mid-cycle
        do_reset();
        for (int i = 0; i < 5; i++) issue(1, 5'(i + 1), 0, 0, 0);
        cdb(0, 32'h99, 0);
        idle();
        #2 reset = 0;
        #1;
        model_reset();
        check_eq("t6_unl", 32'(bus.unlock), 0);
        check_eq("t6_val", bus.unlock_val, 0);
        check_eq("t6_pos", 32'(bus.alloc_robpos), 0);
        @(negedge clk);
        reset = 1;
        idle();
        check_eq("t6_full", 32'(bus.full), 0);

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            idle_inputs();
            bus.ready = ($urandom_range(0, 9) != 0);
            bus.issue_valid = ($urandom_range(0, 9) < 6);
            bus.issue_has_rd = 1'($urandom);
            bus.issue_rd = 5'($urandom);
            bus.issue_is_branch = ($urandom_range(0, 9) < 2);
            bus.issue_pred_taken = 1'($urandom);
            bus.issue_alt_pc = $urandom;
            bus.cdb_valid = ($urandom_range(0, 9) < 6);
            bus.cdb_val = $urandom;
            bus.cdb_taken = ($urandom_range(0, 3) == 0) ? ~bus.issue_pred_taken : 1'($urandom);
            if (rob.size() > 0 && $urandom_range(0, 4) != 0)
                bus.cdb_robpos = rob[$urandom_range(0, rob.size() - 1)].pos;
            else
                bus.cdb_robpos = 4'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- Reorder buffer for the out-of-order RISC-V core, and the producer side of the register-file lock/unlock interface.
- Allocates entries in program order for issue, and hands out the ROB index that the register file stores as a register's tag.
- Collects results from the CDB and retires entries in order, driving unlock_rd/unlock_robpos/unlock_val to the register file.
- On a branch mispredict, raises clear with the redirect PC.

Parameters:
ROB_SIZE  16  number of entries; must be a power of two
ROB_W  4  index width, log2(ROB_SIZE); matches the register-file tag width
REG_W  5  architectural register index width
DATA_W  32  data and PC width

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  asynchronous, active-low reset (asserted when 0)
ready  in  1  global stall; when 0, all state holds
issue_valid  in  1  allocate one entry this cycle
issue_has_rd  in  1  instruction writes rd
issue_rd  in  REG_W  destination register
issue_is_branch  in  1  conditional branch or jalr
issue_pred_taken  in  1  predicted direction
issue_alt_pc  in  DATA_W  redirect PC if the prediction is wrong
alloc_robpos  out  ROB_W  index given to the issuing instruction; equals tail
full  out  1  no free entry
cdb_valid  in  1  a result is broadcast this cycle
cdb_robpos  in  ROB_W  entry that produced the result
cdb_val  in  DATA_W  result value
cdb_taken  in  1  actual branch direction
unlock  out  1  commit pulse to the register file
unlock_rd  out  REG_W  committed destination register
unlock_robpos  out  ROB_W  committed entry index
unlock_val  out  DATA_W  committed value
clear  out  1  flush pulse for the whole core
clear_pc  out  DATA_W  fetch redirect target

Behaviour:
- Storage: circular buffer with head, tail and count. Each entry holds busy, done, has_rd, rd, is_branch, pred, taken, val and alt_pc.
- Reset (reset==0, asynchronous):
  - head = tail = count = 0.
  - All busy and done bits cleared.
  - unlock, clear, unlock_rd, unlock_robpos, unlock_val and clear_pc all 0.
- full = (count == ROB_SIZE). alloc_robpos = tail; both are combinational.
- ready==0: no state changes. unlock and clear are driven 0 in the next cycle.
- Allocation (ready && issue_valid && !full && !clear):
  - Write the entry at tail with busy=1, done=0.
  - tail advances by 1 modulo ROB_SIZE, wrapping 15 to 0.
  - Allocating while full is ignored; the issuer must not do it.
- CDB (ready && cdb_valid && !clear):
  - Set done=1, val=cdb_val and taken=cdb_taken at cdb_robpos.
  - A CDB write to a non-busy entry is ignored.
- Commit: at most one entry per cycle. An entry commits when ready, the head entry is busy and done, and clear is currently 0.
  - Registered outputs in the cycle after the commit edge, each a single-cycle pulse:
    - unlock = has_rd, unlock_rd = rd, unlock_robpos = head, unlock_val = val.
    - If is_branch and taken != pred: clear = 1 and clear_pc = alt_pc.
  - A mispredicted jalr with rd != 0 asserts unlock and clear in the same cycle.
  - Normal commit: head advances by 1 and the entry's busy is cleared.
  - Mispredict commit: head = tail = count = 0 and all busy bits cleared.
- Latency:
  - A CDB result at edge N makes the head done at N.
  - The earliest commit decision is at edge N+1; unlock is visible after edge N+1.
- count bookkeeping:
  - Allocate and commit in the same edge: count unchanged.
  - Allocate only: +1. Commit only: -1.
  - A flush overrides any allocation in the same edge.
- While clear==1, issue and CDB inputs are ignored and no commit occurs. The buffer is already empty, so this cycle drains.
- Full with simultaneous commit: full is still 1 that cycle, so allocation is refused. The freed slot is usable from the next cycle.
- Reset asserted mid-operation discards all in-flight entries immediately.

Test Plan:
- Reset, then 3 allocations with rd=1,2,3 → alloc_robpos 0,1,2 and count=3. CDB for robpos 1 then 0 with values 0xA, 0xB → unlock for robpos 0 (rd=1, val=0xB) then robpos 1 (rd=2, val=0xA) on consecutive cycles. robpos 2 does not commit until its CDB arrives.
- Allocate 16 entries → full=1, and a 17th issue_valid is ignored. Commit robpos 0, then allocate → alloc_robpos wraps to 0 and full returns to 1.
- Branch with pred=0, CDB taken=1, alt_pc=0x1000, plus 2 younger done entries → clear=1 and clear_pc=0x1000 for one cycle. Next cycle count=0 and alloc_robpos=0; the younger entries never unlock.
- Mispredicted jalr with rd=5, val=0x44 → unlock (rd=5, val=0x44) and clear both asserted in the same cycle.
- Hold ready=0 for 3 cycles with a done head and CDB/issue traffic → no unlock and no state change. Head commits on the first ready cycle.
- Drive reset low asynchronously between clock edges with 5 busy entries → outputs go 0 immediately. After release, alloc_robpos=0 and full=0.
